// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package cpu_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned IR_W   = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TGT_W  = 15;

  // Unused gaps inside each instruction format
  localparam int unsigned MEM_PAD_W = 8;   // memory type, IR[23:16]
  localparam int unsigned BR_PAD_W  = 4;   // branch type, IR[18:15]
  localparam int unsigned ALU_PAD_W = 14;  // arithmetic type, IR[13:0]

  // IR field positions (LSB of each 5-bit register field)
  localparam int unsigned OP_LSB = IR_W - OP_W;          // 29
  localparam int unsigned F0_LSB = ADDR_W + MEM_PAD_W;   // 24
  localparam int unsigned F1_LSB = TGT_W + BR_PAD_W;     // 19
  localparam int unsigned F2_LSB = ALU_PAD_W;            // 14

  typedef enum logic [OP_W-1:0] {
    OP_LW  = 3'b000,
    OP_SW  = 3'b001,
    OP_BEQ = 3'b010,
    OP_BLT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_AND = 3'b110,
    OP_OR  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    CLS_MEM    = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_ALU    = 2'd2
  } iclass_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    opcode_e           op;
    iclass_e           cls;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [PC_W-1:0]   target;
  } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR word -> opcode, class, register addresses, target.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [IR_W-1:0] i_ir,
  output dec_t            o_dec
);

  opcode_e w_op;

  assign w_op = opcode_e'(i_ir[OP_LSB +: OP_W]);

  // Field extraction depends on the instruction format
  always_comb begin
    o_dec          = '0;
    o_dec.op       = w_op;
    o_dec.mem_addr = i_ir[0 +: ADDR_W];
    o_dec.target   = PC_W'(i_ir[0 +: TGT_W]);
    case (w_op)
      OP_LW: begin
        o_dec.cls = CLS_MEM;
        o_dec.wr  = i_ir[F0_LSB +: REG_AW];
      end
      OP_SW: begin
        o_dec.cls = CLS_MEM;
        o_dec.rb  = i_ir[F0_LSB +: REG_AW];
      end
      OP_BEQ, OP_BLT: begin
        o_dec.cls = CLS_BRANCH;
        o_dec.ra  = i_ir[F0_LSB +: REG_AW];
        o_dec.rb  = i_ir[F1_LSB +: REG_AW];
      end
      default: begin
        o_dec.cls = CLS_ALU;
        o_dec.wr  = i_ir[F0_LSB +: REG_AW];
        o_dec.ra  = i_ir[F1_LSB +: REG_AW];
        o_dec.rb  = i_ir[F2_LSB +: REG_AW];
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch/decode/exec/mem/wb with PC and retire counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PROG_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   inst_address,
  input  logic [IR_W-1:0]   inst_data,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic [OP_W-1:0]   alu_op,
  output logic [REG_AW-1:0] ra_addr,
  output logic [REG_AW-1:0] rb_addr,
  output logic [REG_AW-1:0] wr_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              wb_sel,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_e            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt, w_pc_upd;
  logic [CNT_W-1:0]  r_retired, w_retired_nxt;
  dec_t              r_dec, w_dec_nxt, w_dec_fetch;
  logic              w_retire;

  logic [OP_W-1:0]   r_alu_op, w_alu_op_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic              r_reg_write, w_reg_write_nxt;
  logic              r_wb_sel, w_wb_sel_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_halted, w_halted_nxt;

  // Decode the word arriving from instruction memory; latched as the IR at fetch
  instr_decode u_decode (
    .i_ir  (inst_data),
    .o_dec (w_dec_fetch)
  );

  // Next-state, PC/retire update and next value of every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_retired_nxt   = r_retired;
    w_dec_nxt       = r_dec;
    w_retire        = 1'b0;
    w_pc_upd        = r_pc + PC_W'(1);
    w_alu_op_nxt    = '0;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_reg_write_nxt = 1'b0;
    w_wb_sel_nxt    = 1'b0;
    w_busy_nxt      = 1'b0;
    w_halted_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pc_nxt = '0;
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_dec_nxt   = w_dec_fetch;
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (r_dec.cls)
          CLS_ALU: w_state_nxt = ST_WB;
          CLS_MEM: w_state_nxt = ST_MEM;
          default: begin
            w_retire = 1'b1;
            if ((r_dec.op == OP_BEQ && alu_zero) || (r_dec.op == OP_BLT && alu_neg))
              w_pc_upd = r_dec.target;
          end
        endcase
      end
      ST_MEM: begin
        if (r_dec.op == OP_LW) w_state_nxt = ST_WB;
        else                   w_retire    = 1'b1;
      end
      ST_WB: w_retire = 1'b1;
      ST_HALT: begin
        if (start) begin
          w_pc_nxt      = '0;
          w_retired_nxt = '0;
          w_state_nxt   = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Retiring an instruction moves the PC; reaching the program end halts
    if (w_retire) begin
      w_pc_nxt      = w_pc_upd;
      w_retired_nxt = (r_retired == '1) ? r_retired : r_retired + CNT_W'(1);
      w_state_nxt   = (w_pc_upd == PC_W'(PROG_LEN)) ? ST_HALT : ST_FETCH;
    end

    w_busy_nxt   = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALT);
    w_halted_nxt = (w_state_nxt == ST_HALT);
    if (w_state_nxt == ST_EXEC) begin
      case (w_dec_nxt.cls)
        CLS_ALU:    w_alu_op_nxt = OP_W'(w_dec_nxt.op);
        CLS_BRANCH: w_alu_op_nxt = OP_W'(OP_SUB);
        default:    w_alu_op_nxt = '0;
      endcase
    end
    w_mem_read_nxt  = (w_state_nxt == ST_MEM) && (w_dec_nxt.op == OP_LW);
    w_mem_write_nxt = (w_state_nxt == ST_MEM) && (w_dec_nxt.op == OP_SW);
    w_reg_write_nxt = (w_state_nxt == ST_WB) && (w_dec_nxt.wr != '0);
    w_wb_sel_nxt    = (w_state_nxt == ST_WB) && (w_dec_nxt.op == OP_LW);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_retired   <= '0;
      r_dec       <= '0;
      r_alu_op    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_retired   <= w_retired_nxt;
      r_dec       <= w_dec_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_reg_write <= w_reg_write_nxt;
      r_wb_sel    <= w_wb_sel_nxt;
      r_busy      <= w_busy_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  assign inst_address = r_pc;
  assign retired      = r_retired;
  assign ra_addr      = r_dec.ra;
  assign rb_addr      = r_dec.rb;
  assign wr_addr      = r_dec.wr;
  assign mem_addr     = r_dec.mem_addr;
  assign alu_op       = r_alu_op;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign reg_write    = r_reg_write;
  assign wb_sel       = r_wb_sel;
  assign busy         = r_busy;
  assign halted       = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed program plus random programs against an instruction-level model.
module tb_cpu_sequencer;

  localparam int unsigned PLEN = 14;

  logic        clk = 1'b0;
  logic        rst, start, alu_zero, alu_neg;
  logic [15:0] inst_address, mem_addr, retired;
  logic [31:0] inst_data;
  logic [2:0]  alu_op;
  logic [4:0]  ra_addr, rb_addr, wr_addr;
  logic        mem_read, mem_write, reg_write, wb_sel, busy, halted;

  logic [31:0] prog [16];
  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 running, 2 halted; m_k = cycle index inside current instruction
  int          m_mode;
  int          m_k;
  logic [15:0] m_pc, m_ret;
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  assign inst_data = (inst_address < 16'd16) ? prog[inst_address[3:0]] : 32'h0;

  cpu_sequencer #(.PROG_LEN(PLEN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .inst_address(inst_address), .inst_data(inst_data),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_op(alu_op),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .wr_addr(wr_addr), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .busy(busy), .halted(halted), .retired(retired)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_mem(input logic [2:0] op, input logic [4:0] r, input logic [15:0] a);
    return {op, r, 8'h00, a};
  endfunction

  function automatic logic [31:0] mk_alu(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 14'h0};
  endfunction

  function automatic logic [31:0] mk_br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [14:0] t);
    return {op, rs, rt, 4'h0, t};
  endfunction

  // Cycles per instruction class
  function automatic int lat(input logic [31:0] ir);
    case (ir[31:29])
      3'b010, 3'b011: return 3;
      3'b000:         return 5;
      default:        return 4;
    endcase
  endfunction

  task automatic exp_fields(input logic [31:0] ir, output logic [4:0] ra, output logic [4:0] rb, output logic [4:0] wr);
    logic [2:0] op;
    op = ir[31:29];
    ra = 5'd0; rb = 5'd0; wr = 5'd0;
    if (op == 3'd0)                    wr = ir[28:24];
    else if (op == 3'd1)               rb = ir[28:24];
    else if (op == 3'd2 || op == 3'd3) begin ra = ir[28:24]; rb = ir[23:19]; end
    else begin wr = ir[28:24]; ra = ir[23:19]; rb = ir[18:14]; end
  endtask

  // Compare every DUT output with what the model says for this cycle
  task automatic check_cycle();
    logic [2:0] op, e_alu;
    logic [4:0] era, erb, ewr;
    logic       run, last, e_rd, e_wr, e_rw, e_sel;
    op   = m_ir[31:29];
    exp_fields(m_ir, era, erb, ewr);
    run  = (m_mode == 1);
    last = run && (m_k == lat(m_ir) - 1);
    e_alu = 3'd0;
    if (run && m_k == 2) begin
      if (op == 3'd2 || op == 3'd3) e_alu = 3'b101;
      else if (op >= 3'd4)          e_alu = op;
    end
    e_rd  = run && m_k == 3 && op == 3'd0;
    e_wr  = run && m_k == 3 && op == 3'd1;
    e_rw  = last && (op == 3'd0 || op >= 3'd4) && (ewr != 5'd0);
    e_sel = last && op == 3'd0;
    chk("busy",      32'(busy),         32'(run));
    chk("halted",    32'(halted),       32'(m_mode == 2));
    chk("pc",        32'(inst_address), 32'(m_pc));
    chk("retired",   32'(retired),      32'(m_ret));
    chk("ra_addr",   32'(ra_addr),      32'(era));
    chk("rb_addr",   32'(rb_addr),      32'(erb));
    chk("wr_addr",   32'(wr_addr),      32'(ewr));
    chk("mem_addr",  32'(mem_addr),     32'(m_ir[15:0]));
    chk("alu_op",    32'(alu_op),       32'(e_alu));
    chk("mem_read",  32'(mem_read),     32'(e_rd));
    chk("mem_write", 32'(mem_write),    32'(e_wr));
    chk("reg_write", 32'(reg_write),    32'(e_rw));
    chk("wb_sel",    32'(wb_sel),       32'(e_sel));
    chk("strobe_excl", 32'((int'(mem_read) + int'(mem_write) + int'(reg_write)) <= 1), 32'd1);
  endtask

  // Advance the model across one rising edge using the inputs the DUT saw
  task automatic model_step();
    logic [2:0]  op;
    logic [15:0] npc;
    logic        taken;
    if (rst) begin
      m_mode = 0; m_pc = 16'd0; m_ret = 16'd0; m_ir = 32'h0; m_k = 0;
      return;
    end
    case (m_mode)
      0: if (start) begin m_mode = 1; m_pc = 16'd0; m_k = 0; end
      2: if (start) begin m_mode = 1; m_pc = 16'd0; m_ret = 16'd0; m_k = 0; end
      default: begin
        if (m_k == 0) begin
          m_ir = (m_pc < 16'd16) ? prog[m_pc[3:0]] : 32'h0;
          m_k  = 1;
        end else if (m_k == lat(m_ir) - 1) begin
          op    = m_ir[31:29];
          taken = (op == 3'd2 && alu_zero) || (op == 3'd3 && alu_neg);
          npc   = taken ? {1'b0, m_ir[14:0]} : m_pc + 16'd1;
          m_pc  = npc;
          if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
          m_k   = 0;
          if (npc == 16'(PLEN)) m_mode = 2;
        end else begin
          m_k++;
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [2:0]  op;
    w  = $urandom;
    op = 3'($urandom_range(0, 7));
    w[31:29] = op;
    if (op == 3'd2 || op == 3'd3) w[14:0] = 15'($urandom_range(0, PLEN - 1));
    return w;
  endfunction

  initial begin
    logic [4:0] lw_regs [7];
    lw_regs = '{5'd7, 5'd6, 5'd1, 5'd2, 5'd8, 5'd9, 5'd4};
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    for (int i = 0; i < 7; i++) prog[i] = mk_mem(3'b000, lw_regs[i], 16'(16'h0020 + i));
    prog[7]  = mk_alu(3'b100, 5'd0,  5'd7, 5'd6);
    prog[8]  = mk_br (3'b011, 5'd1,  5'd2, 15'd7);
    prog[9]  = mk_br (3'b010, 5'd9,  5'd4, 15'd13);
    prog[10] = mk_alu(3'b111, 5'd10, 5'd1, 5'd2);
    prog[11] = mk_alu(3'b110, 5'd11, 5'd3, 5'd4);
    prog[12] = mk_alu(3'b101, 5'd12, 5'd5, 5'd6);
    prog[13] = mk_mem(3'b001, 5'd5, 16'd3);

    rst = 1'b1; start = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    m_mode = 0; m_pc = 16'd0; m_ret = 16'd0; m_ir = 32'h0; m_k = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_halted",    32'(halted),       32'd0);
    chk("rst_pc",        32'(inst_address), 32'd0);
    chk("rst_retired",   32'(retired),      32'd0);
    chk("rst_alu_op",    32'(alu_op),       32'd0);
    chk("rst_strobes",   32'({mem_read, mem_write, reg_write, wb_sel}), 32'd0);
    rst = 1'b0;

    // Run A: beq taken, blt not taken -> 49 cycles, 11 retired
    alu_zero = 1'b1; alu_neg = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (3) cycle();
    chk("lw0_mem_read", 32'(mem_read), 32'd1);
    chk("lw0_mem_addr", 32'(mem_addr), 32'h20);
    cycle();
    chk("lw0_reg_write", 32'(reg_write), 32'd1);
    chk("lw0_wb_sel",    32'(wb_sel),    32'd1);
    chk("lw0_wr_addr",   32'(wr_addr),   32'd7);
    repeat (45) cycle();
    chk("A_halted",  32'(halted),       32'd1);
    chk("A_busy",    32'(busy),         32'd0);
    chk("A_pc",      32'(inst_address), 32'd14);
    chk("A_retired", 32'(retired),      32'd11);

    // Restart from HALT, then hold start while busy
    start = 1'b1; cycle();
    chk("restart_pc",      32'(inst_address), 32'd0);
    chk("restart_retired", 32'(retired),      32'd0);
    chk("restart_busy",    32'(busy),         32'd1);
    repeat (5) cycle();
    chk("busy_start_pc",      32'(inst_address), 32'd1);
    chk("busy_start_retired", 32'(retired),      32'd1);
    start = 1'b0;
    repeat (3) cycle();
    chk("lw1_mem_read", 32'(mem_read), 32'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("midrst_mem_read",  32'(mem_read),     32'd0);
    chk("midrst_reg_write", 32'(reg_write),    32'd0);
    chk("midrst_pc",        32'(inst_address), 32'd0);
    chk("midrst_retired",   32'(retired),      32'd0);
    chk("midrst_busy",      32'(busy),         32'd0);

    // Run B: no branch taken -> 61 cycles, 14 retired; add to r0 writes nothing
    alu_zero = 1'b0; alu_neg = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (38) cycle();
    chk("r0_reg_write", 32'(reg_write),    32'd0);
    chk("r0_wr_addr",   32'(wr_addr),      32'd0);
    chk("r0_pc",        32'(inst_address), 32'd7);
    repeat (23) cycle();
    chk("B_halted",  32'(halted),  32'd1);
    chk("B_retired", 32'(retired), 32'd14);

    // Random programs, flags, start pulses and occasional resets
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) prog[i] = rand_word();
      rst = 1'b1; start = 1'b0; cycle(); rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
        start    = ($urandom_range(0, 5) == 0);
        alu_zero = 1'($urandom_range(0, 1));
        alu_neg  = 1'($urandom_range(0, 1));
        rst      = ($urandom_range(0, 249) == 0);
        cycle();
      end
      rst = 1'b0; start = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
